// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, bounded bursts, no switch bubble.
// Grant/ack is combinational from registered state; read data returns READ_LATENCY cycles after ack, tagged per owner.
module data_port_arbiter #(
  parameter int ADDR_SIZE    = 18,
  parameter int WORD_SIZE    = 18,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 r0_req,
  input  logic                 r0_wren,
  input  logic [ADDR_SIZE-1:0] r0_addr,
  input  logic [WORD_SIZE-1:0] r0_wdata,
  output logic                 r0_ack,
  output logic                 r0_rvalid,
  input  logic                 r1_req,
  input  logic                 r1_wren,
  input  logic [ADDR_SIZE-1:0] r1_addr,
  input  logic [WORD_SIZE-1:0] r1_wdata,
  output logic                 r1_ack,
  output logic                 r1_rvalid,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_write,
  output logic                 mem_wren,
  input  logic [WORD_SIZE-1:0] mem_read
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                  state;
  logic                    last_owner;
  logic [CW-1:0]           cnt;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [READ_LATENCY-1:0] pipe_own;
  logic                    grant0;
  logic                    grant1;
  logic                    rd_issue;
  logic                    burst_open;

  assign burst_open = (cnt < CW'(MAX_BURST));

  // Grants are held off while reset is asserted so no ack escapes during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (r0_req && r1_req) begin
            grant0 = last_owner;
            grant1 = !last_owner;
          end else begin
            grant0 = r0_req;
            grant1 = r1_req;
          end
        end
        OWN0: begin
          if (r0_req && (burst_open || !r1_req)) grant0 = 1'b1;
          else                                   grant1 = r1_req;
        end
        OWN1: begin
          if (r1_req && (burst_open || !r0_req)) grant1 = 1'b1;
          else                                   grant0 = r0_req;
        end
        default: ;
      endcase
    end
  end

  assign r0_ack   = grant0;
  assign r1_ack   = grant1;
  assign rd_issue = (grant0 && !r0_wren) || (grant1 && !r1_wren);

  always_comb begin
    mem_address = '0;
    mem_write   = '0;
    mem_wren    = 1'b0;
    if (grant0) begin
      mem_address = r0_addr;
      mem_write   = r0_wdata;
      mem_wren    = r0_wren;
    end else if (grant1) begin
      mem_address = r1_addr;
      mem_write   = r1_wdata;
      mem_wren    = r1_wren;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      pipe_vld   <= '0;
      pipe_own   <= '0;
    end else begin
      if (grant0) begin
        last_owner <= 1'b0;
        state      <= OWN0;
        if (state != OWN0) cnt <= CW'(1);
        else if (burst_open) cnt <= cnt + CW'(1);
      end else if (grant1) begin
        last_owner <= 1'b1;
        state      <= OWN1;
        if (state != OWN1) cnt <= CW'(1);
        else if (burst_open) cnt <= cnt + CW'(1);
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
      // Owner tag travels with the read so mixed-owner reads return in issue order.
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= grant1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign r0_rvalid = pipe_vld[READ_LATENCY-1] && !pipe_own[READ_LATENCY-1];
  assign r1_rvalid = pipe_vld[READ_LATENCY-1] &&  pipe_own[READ_LATENCY-1];
  assign rdata     = mem_read;

endmodule
